// File: rtl/rf_pkg.sv
// Shared register-file constants, the pending-counter operation type and a
// constant-foldable log2 helper used to derive address widths.
package rf_pkg;

    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10
    } cnt_op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_pending_ctr.sv
// Saturating up/down counter tracking outstanding producers of one register.
// Increment never passes all-ones; decrement never goes below zero.
module rf_pending_ctr
    import rf_pkg::*;
#(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              sat_o,
    output logic              zero_o
);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    logic              inc_eff;
    logic              dec_eff;
    cnt_op_e           op;

    assign sat_o   = &cnt_q;
    assign zero_o  = ~|cnt_q;
    assign cnt_o   = cnt_q;
    assign inc_eff = inc_i && !sat_o;
    assign dec_eff = dec_i && !zero_o;

    always_comb begin
        op    = CNT_HOLD;
        cnt_d = cnt_q;
        if (inc_eff && !dec_eff) begin
            op = CNT_INC;
        end else if (dec_eff && !inc_eff) begin
            op = CNT_DEC;
        end
        case (op)
            CNT_INC: cnt_d = cnt_q + PEND_W'(1);
            CNT_DEC: cnt_d = cnt_q - PEND_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_scoreboard_mp.sv
// Multi-read-port register file with optional write->read bypass and a
// per-register pending-producer scoreboard feeding the hazard/stall unit.
module rf_scoreboard_mp
    import rf_pkg::*;
#(
    parameter  int unsigned DW     = DW_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    parameter  int unsigned NUM_RD = 2,
    parameter  int unsigned BYPASS = 1,
    parameter  int unsigned PEND_W = 2,
    localparam int unsigned AW     = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic                 iss_full,
    output logic                 err_unf
);

    logic [DW-1:0]     rf_q [DEPTH];
    logic [PEND_W-1:0] cnt_w [DEPTH];
    logic [DEPTH-1:0]  sat_w;
    logic [DEPTH-1:0]  zero_w;
    logic              err_q;
    logic              err_d;
    logic              wr_live;

    assign wr_live  = wr_en && (wr_addr != AW'(REG_ZERO));
    assign iss_full = iss_en && (iss_addr != AW'(REG_ZERO)) && sat_w[iss_addr];
    assign err_unf  = err_q;
    assign err_d    = err_q || (wr_live && zero_w[wr_addr]);

    // Register 0 has no counter: it is permanently idle.
    assign cnt_w[0]  = '0;
    assign sat_w[0]  = 1'b0;
    assign zero_w[0] = 1'b1;

    for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
        logic inc;
        logic dec;
        assign inc = iss_en && (iss_addr == AW'(r)) && !iss_full;
        assign dec = wr_en && (wr_addr == AW'(r));

        rf_pending_ctr #(
            .PEND_W (PEND_W)
        ) u_ctr (
            .clk_i  (clk),
            .rst_i  (rst),
            .inc_i  (inc),
            .dec_i  (dec),
            .cnt_o  (cnt_w[r]),
            .sat_o  (sat_w[r]),
            .zero_o (zero_w[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_live) begin
                rf_q[wr_addr] <= wr_data;
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        logic          wr_hit;
        a       = '0;
        wr_hit  = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            a      = rd_addr[p*AW +: AW];
            wr_hit = wr_en && (wr_addr == a);
            if (a != AW'(REG_ZERO)) begin
                if ((BYPASS != 0) && wr_hit) begin
                    rd_data[p*DW +: DW] = wr_data;
                end else begin
                    rd_data[p*DW +: DW] = rf_q[a];
                end
                // With bypass, the final writeback frees the consumer in the same cycle.
                if (BYPASS != 0) begin
                    rd_busy[p] = (cnt_w[a] > PEND_W'(1)) ||
                                 ((cnt_w[a] == PEND_W'(1)) && !wr_hit);
                end else begin
                    rd_busy[p] = !zero_w[a];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard_mp.sv
// Directed table-driven bench for rf_scoreboard_mp, with a BYPASS=0 twin
// sharing the same stimulus for latency comparison.
module tb_rf_scoreboard_mp;

    logic        clk;
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [63:0] rd_data_b1, rd_data_b0;
    logic [1:0]  rd_busy_b1, rd_busy_b0;
    logic        iss_full_b1, iss_full_b0;
    logic        err_unf_b1, err_unf_b0;

    int n_cmp;
    int n_fail;

    rf_scoreboard_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .PEND_W(2)) dut (
        .clk(clk), .rst(rst), .rd_addr({ra1, ra0}), .rd_data(rd_data_b1),
        .rd_busy(rd_busy_b1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(iss_full_b1), .err_unf(err_unf_b1)
    );

    rf_scoreboard_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0), .PEND_W(2)) dut0 (
        .clk(clk), .rst(rst), .rd_addr({ra1, ra0}), .rd_data(rd_data_b0),
        .rd_busy(rd_busy_b0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(iss_full_b0), .err_unf(err_unf_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        ef;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic ie, logic [4:0] ia, logic [4:0] r0, logic [4:0] r1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb,
                                logic ef, logic ee);
        vec_t v;
        v.nm = nm; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ef = ef; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; ra0 = r0; ra1 = r1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #3;
        chk("reset_data", rd_data_b1[31:0], 32'h0);
        chk("reset_busy", 32'(rd_busy_b1), 32'h0);
        chk("reset_err",  32'(err_unf_b1), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        //            name        we  wa  wd            ie  ia  r0  r1  e0            e1            eb     ef  ee
        vecs.push_back(mk("idle",  0, 0, 32'h0,        0, 0,  5,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("iss3",  0, 0, 32'h0,        1, 3,  3,  7, 32'h0,        32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("busy3", 0, 0, 32'h0,        0, 0,  3,  0, 32'h0,        32'h0,        2'b01, 0, 0));
        vecs.push_back(mk("byp3",  1, 3, 32'h12345678, 0, 0,  3,  3, 32'h12345678, 32'h12345678, 2'b00, 0, 0));
        vecs.push_back(mk("rd3",   0, 0, 32'h0,        0, 0,  3,  0, 32'h12345678, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("x0wr",  1, 0, 32'hFFFFFFFF, 1, 0,  0,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("x0rd",  0, 0, 32'h0,        0, 0,  0,  3, 32'h0,        32'h12345678, 2'b00, 0, 0));
        vecs.push_back(mk("iss7a", 0, 0, 32'h0,        1, 7,  7,  7, 32'h0,        32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("iss7b", 0, 0, 32'h0,        1, 7,  7,  7, 32'h0,        32'h0,        2'b11, 0, 0));
        vecs.push_back(mk("wb7a",  1, 7, 32'hAAAA0001, 0, 0,  7,  7, 32'hAAAA0001, 32'hAAAA0001, 2'b11, 0, 0));
        vecs.push_back(mk("wb7b",  1, 7, 32'hAAAA0002, 0, 0,  7,  0, 32'hAAAA0002, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("rd7",   0, 0, 32'h0,        0, 0,  7,  7, 32'hAAAA0002, 32'hAAAA0002, 2'b00, 0, 0));
        vecs.push_back(mk("iss9a", 0, 0, 32'h0,        1, 9,  9,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("iss9b", 0, 0, 32'h0,        1, 9,  9,  0, 32'h0,        32'h0,        2'b01, 0, 0));
        vecs.push_back(mk("isswb9",1, 9, 32'h00000099, 1, 9,  9,  9, 32'h00000099, 32'h00000099, 2'b11, 0, 0));
        vecs.push_back(mk("iss9c", 0, 0, 32'h0,        1, 9,  9,  0, 32'h00000099, 32'h0,        2'b01, 0, 0));
        vecs.push_back(mk("full9", 0, 0, 32'h0,        1, 9,  9,  0, 32'h00000099, 32'h0,        2'b01, 1, 0));
        vecs.push_back(mk("fullwb",1, 9, 32'h00000100, 1, 9,  9,  0, 32'h00000100, 32'h0,        2'b01, 1, 0));
        vecs.push_back(mk("rd9",   0, 0, 32'h0,        0, 0,  9,  0, 32'h00000100, 32'h0,        2'b01, 0, 0));
        vecs.push_back(mk("drn9a", 1, 9, 32'h00000101, 0, 0,  9,  0, 32'h00000101, 32'h0,        2'b01, 0, 0));
        vecs.push_back(mk("drn9b", 1, 9, 32'h00000102, 0, 0,  9,  0, 32'h00000102, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("idle9", 0, 0, 32'h0,        0, 0,  9,  0, 32'h00000102, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk("unf4",  1, 4, 32'h00004444, 0, 0,  4,  4, 32'h00004444, 32'h00004444, 2'b00, 0, 0));
        vecs.push_back(mk("err4",  0, 0, 32'h0,        0, 0,  4,  0, 32'h00004444, 32'h0,        2'b00, 0, 1));
        vecs.push_back(mk("errstk",0, 0, 32'h0,        0, 0,  0,  0, 32'h0,        32'h0,        2'b00, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ia, vecs[i].r0, vecs[i].r1);
            #3;
            chk({vecs[i].nm, "_d0"},   rd_data_b1[31:0],  vecs[i].e0);
            chk({vecs[i].nm, "_d1"},   rd_data_b1[63:32], vecs[i].e1);
            chk({vecs[i].nm, "_busy"}, 32'(rd_busy_b1),   32'(vecs[i].eb));
            chk({vecs[i].nm, "_full"}, 32'(iss_full_b1),  32'(vecs[i].ef));
            chk({vecs[i].nm, "_err"},  32'(err_unf_b1),   32'(vecs[i].ee));
            step();
        end

        // Mid-run asynchronous reset with cnt[5]=2 and rf[5]=0xDEAD.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd5);
        step(); step(); step();
        drive(1'b1, 5'd5, 32'h0000DEAD, 1'b0, 5'd0, 5'd5, 5'd5);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
        chk("pre_rst_data", rd_data_b1[31:0], 32'h0000DEAD);
        chk("pre_rst_busy", 32'(rd_busy_b1), 32'h3);
        rst = 1'b1;
        #1;
        chk("rst_data0", rd_data_b1[31:0],  32'h0);
        chk("rst_data1", rd_data_b1[63:32], 32'h0);
        chk("rst_busy",  32'(rd_busy_b1),   32'h0);
        chk("rst_err",   32'(err_unf_b1),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // BYPASS=0 twin: old value in the write cycle, new value one cycle later.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        step();
        drive(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd0);
        #3;
        chk("b1_wr_data", rd_data_b1[31:0], 32'h12345678);
        chk("b1_wr_busy", 32'(rd_busy_b1),  32'h0);
        chk("b0_wr_data", rd_data_b0[31:0], 32'h0);
        chk("b0_wr_busy", 32'(rd_busy_b0),  32'h1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
        #3;
        chk("b0_nx_data", rd_data_b0[31:0], 32'h12345678);
        chk("b0_nx_busy", 32'(rd_busy_b0),  32'h0);
        chk("b1_nx_err",  32'(err_unf_b1),  32'h0);

        // Writeback to r5 after reset: its pre-reset issues were discarded.
        drive(1'b1, 5'd5, 32'h00000001, 1'b0, 5'd0, 5'd5, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #3;
        chk("post_rst_unf_err",  32'(err_unf_b1), 32'h1);
        chk("post_rst_unf_busy", 32'(rd_busy_b1), 32'h0);
        chk("post_rst_unf_data", rd_data_b1[31:0], 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
